mmu09_clkgen: RTL
=================

MMU09_CLKGEN -- requirements
Module: mmu09_clkgen

Interface
REQ-001 Parameter DIV, default 1: clk cycles per quarter phase of the Q/E clocks (>=1).
REQ-002 Parameter RST_CYCLES, default 16: E cycles that cpu_reset_n is held low after reset.
REQ-003 Parameter NCHAN, default 3: number of interrupt channels.
REQ-004 Parameter CTR_W, default 32: width of the E-cycle counter and channel start/period registers.
REQ-005 clk  in  1  four-phase master clock; only clock in the block.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cfg_we  in  1  config write strobe, one clk.
REQ-008 cfg_chan  in  $clog2(NCHAN) (min 1)  target channel.
REQ-009 cfg_sel  in  2  register select: 0=start, 1=len, 2=period, 3=mode.
REQ-010 cfg_data  in  CTR_W  write data; len uses [7:0], mode uses [1:0].
REQ-011 qclk  out  1  6809 Q clock.
REQ-012 eclk  out  1  6809 E clock; lags qclk by one quarter phase.
REQ-013 cpu_reset_n  out  1  stretched CPU reset, active low.
REQ-014 ecount  out  CTR_W  E cycles completed since reset.
REQ-015 int_n  out  NCHAN  active-low interrupt outputs; by convention bit0=IRQ, bit1=FIRQ, bit2=NMI.
REQ-016 chan_busy  out  NCHAN  high while a channel is in WAIT or ACTIVE.

Function
REQ-017 A prescaler counts 0..DIV-1; phase p (2 bits) advances by 1 (mod 4) on the clk where the prescaler wraps.
REQ-018 qclk and eclk are registered: qclk=1 when p in {0,1}; eclk=1 when p in {1,2}.
REQ-019 ecount increments (wrapping) on each p 2->3 transition (E falling).
REQ-020 cpu_reset_n rises on the clk where ecount becomes RST_CYCLES and stays high until reset_n is asserted.
REQ-021 Channel state: OFF, WAIT, ACTIVE, DONE; mode: 0=off, 1=one-shot, 2=periodic, 3=reserved (treated as off).
REQ-022 A mode write of 1 or 2 puts the channel in WAIT; a mode write of 0 or 3 puts it in OFF. Any write to start, len or period leaves an OFF or DONE channel unchanged, and returns a WAIT or ACTIVE channel to WAIT.
REQ-023 Channels are evaluated only on p 0->1 transitions (E rising), using the ecount value at that instant.
REQ-024 WAIT -> ACTIVE when ecount == next; next loads from start on every start or mode write.
REQ-025 While ACTIVE, int_n[c]=0 for exactly max(len,1) E rising edges; the channel then leaves ACTIVE on the next evaluated edge.
REQ-026 On leaving ACTIVE: periodic with period!=0 -> next = next+period (mod 2^CTR_W), WAIT; otherwise -> DONE.
REQ-027 When cfg_we targets channel c on the same clk as an evaluation edge, the write wins and channel c is not evaluated on that edge.
REQ-028 Writes with cfg_chan >= NCHAN are ignored.
REQ-029 Any channel forced out of ACTIVE by a write releases int_n[c] high on the next clk.
REQ-030 int_n is registered and glitch-free; all channels are independent, and simultaneous activation is permitted.

Reset
REQ-031 On reset_n low: prescaler=0, p=3, qclk=0, eclk=0, ecount=0, cpu_reset_n=0, every channel OFF with start=len=period=next=0, int_n all 1, chan_busy all 0.
REQ-032 Reset mid-pulse ends the pulse immediately and asynchronously; after release, the first phase advance gives p=0 and qclk rises.

Structure
REQ-033 Package mmu09_pkg holds the channel-state enum, the mode encodings and the cfg_sel encodings.
REQ-034 Sub-module mmu09_irq_chan implements one channel (registers, next comparator, len counter, FSM) and is instantiated NCHAN times; the top holds the prescaler, phase, ecount and the reset stretcher.

Verification
REQ-035 DIV=1, release reset -> qclk pattern 1,1,0,0 and eclk pattern 0,1,1,0 per 4 clks, first qclk rise on the first clk after release.
REQ-036 DIV=3, RST_CYCLES=16 -> E period 12 clks; cpu_reset_n rises on the clk where ecount becomes 16 and never falls afterwards.
REQ-037 Ch2 one-shot, start=0x1C4, len=1 -> int_n[2] low for exactly one E cycle, starting at the E rise with ecount=0x1C4; then DONE with chan_busy[2]=0.
REQ-038 Ch0 periodic, start=10, len=3, period=20 -> int_n[0] low for E rises 10-12, 30-32 and 50-52.
REQ-039 Rewrite period during ch1 ACTIVE -> int_n[1] high the next clk; WAIT with the original next; a write on the same clk as an evaluation edge suppresses that edge's evaluation.
REQ-040 Assert reset_n mid-pulse -> int_n all 1 and cpu_reset_n=0 immediately; write cfg_chan=3 with NCHAN=3 -> no state change.

Source files
------------

// File: rtl/mmu09_pkg.sv
// -----------------------------------------------------------------------------
// mmu09_pkg
// Shared definitions for the MMU09 clock generator and its interrupt channels:
// channel FSM state encoding, channel mode encodings and config register
// select encodings, plus a small helper that classifies a mode value.
// -----------------------------------------------------------------------------
package mmu09_pkg;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_WAIT   = 2'd1,
    CH_ACTIVE = 2'd2,
    CH_DONE   = 2'd3
  } chan_state_e;

  // Channel mode encodings (cfg_data[1:0] on a mode write).
  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  // Config register select encodings (cfg_sel).
  localparam logic [1:0] SEL_START  = 2'd0;
  localparam logic [1:0] SEL_LEN    = 2'd1;
  localparam logic [1:0] SEL_PERIOD = 2'd2;
  localparam logic [1:0] SEL_MODE   = 2'd3;

  // True for the modes that arm a channel; the reserved mode behaves as off.
  function automatic logic mode_runs(logic [1:0] mode);
    return (mode == MODE_ONESHOT) || (mode == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/mmu09_clkgen_if.sv
// -----------------------------------------------------------------------------
// mmu09_clkgen_if
// Configuration write bus of the MMU09 clock generator.
//   cfg_we   : one-clk write strobe
//   cfg_chan : target interrupt channel
//   cfg_sel  : register select (start / len / period / mode)
//   cfg_data : write data (len uses [7:0], mode uses [1:0])
// master drives the bus, slave (the clock generator) receives it.
// -----------------------------------------------------------------------------
interface mmu09_clkgen_if #(
  parameter int NCHAN = 3,
  parameter int CTR_W = 32
) ();
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic             cfg_we;
  logic [CW-1:0]    cfg_chan;
  logic [1:0]       cfg_sel;
  logic [CTR_W-1:0] cfg_data;

  modport master (output cfg_we, cfg_chan, cfg_sel, cfg_data);
  modport slave  (input  cfg_we, cfg_chan, cfg_sel, cfg_data);
endinterface

// File: rtl/mmu09_irq_chan.sv
// -----------------------------------------------------------------------------
// mmu09_irq_chan
// One timed interrupt channel. Holds its start/len/period/mode registers, the
// next-fire comparator, the pulse length counter and the channel FSM.
//   clk, reset_n : clock, asynchronous active-low reset
//   eval_i       : one-clk strobe on each E rising edge
//   ecount_i     : E-cycle count sampled at that edge
//   we_i         : config write aimed at this channel
//   sel_i/data_i : register select and write data
//   int_n_o      : registered active-low interrupt
//   busy_o       : channel is in WAIT or ACTIVE
// -----------------------------------------------------------------------------
module mmu09_irq_chan
  import mmu09_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             eval_i,
  input  logic [CTR_W-1:0] ecount_i,
  input  logic             we_i,
  input  logic [1:0]       sel_i,
  input  logic [CTR_W-1:0] data_i,
  output logic             int_n_o,
  output logic             busy_o
);

  logic [CTR_W-1:0] start_q;
  logic [CTR_W-1:0] period_q;
  logic [CTR_W-1:0] next_q;
  logic [7:0]       len_q;
  logic [7:0]       cnt_q;   // E rises still owed to the current pulse, minus one
  logic [1:0]       mode_q;
  chan_state_e      state_q;
  logic             int_n_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the config registers are small flops, not RAM, so they are
      // cleared here along with the FSM; a fresh channel must come up idle.
      start_q  <= '0;
      period_q <= '0;
      next_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_OFF;
      state_q  <= CH_OFF;
      int_n_q  <= 1'b1;
    end else if (we_i) begin
      // A write always beats an evaluation on the same clk and drops any
      // pulse in progress; a running channel re-arms with its current next.
      int_n_q <= 1'b1;
      if (state_q == CH_WAIT || state_q == CH_ACTIVE) state_q <= CH_WAIT;
      case (sel_i)
        SEL_START: begin
          start_q <= data_i;
          next_q  <= data_i;
        end
        SEL_LEN:    len_q    <= data_i[7:0];
        SEL_PERIOD: period_q <= data_i;
        default: begin
          mode_q  <= data_i[1:0];
          next_q  <= start_q;
          state_q <= mode_runs(data_i[1:0]) ? CH_WAIT : CH_OFF;
        end
      endcase
    end else if (eval_i) begin
      case (state_q)
        CH_WAIT: begin
          if (ecount_i == next_q) begin
            state_q <= CH_ACTIVE;
            int_n_q <= 1'b0;
            // len of 0 still yields a one-cycle pulse.
            cnt_q   <= (len_q == 8'd0) ? 8'd0 : len_q - 8'd1;
          end
        end
        CH_ACTIVE: begin
          if (cnt_q == 8'd0) begin
            int_n_q <= 1'b1;
            if (mode_q == MODE_PERIODIC && period_q != '0) begin
              next_q  <= next_q + period_q;
              state_q <= CH_WAIT;
            end else begin
              state_q <= CH_DONE;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign int_n_o = int_n_q;
  assign busy_o  = (state_q == CH_WAIT) || (state_q == CH_ACTIVE);

endmodule

// File: rtl/mmu09_clkgen.sv
// -----------------------------------------------------------------------------
// mmu09_clkgen
// 6809 Q/E clock generator with a stretched CPU reset and NCHAN timed
// interrupt channels.
//   clk, reset_n : master clock (four phases per E cycle), async active-low reset
//   cfg          : configuration write bus (slave side)
//   qclk, eclk   : registered Q and E clocks, E lagging Q by a quarter phase
//   cpu_reset_n  : held low until RST_CYCLES E cycles have completed
//   ecount       : E cycles completed since reset (wrapping)
//   int_n        : active-low channel interrupts (bit0 IRQ, bit1 FIRQ, bit2 NMI)
//   chan_busy    : per-channel WAIT/ACTIVE indication
// -----------------------------------------------------------------------------
module mmu09_clkgen
  import mmu09_pkg::*;
#(
  parameter int DIV        = 1,
  parameter int RST_CYCLES = 16,
  parameter int NCHAN      = 3,
  parameter int CTR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mmu09_clkgen_if.slave     cfg,
  output logic              qclk,
  output logic              eclk,
  output logic              cpu_reset_n,
  output logic [CTR_W-1:0]  ecount,
  output logic [NCHAN-1:0]  int_n,
  output logic [NCHAN-1:0]  chan_busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [PW-1:0]    pre_q, pre_d;
  logic [1:0]       ph_q, ph_d;
  logic [CTR_W-1:0] ecount_q, ecount_d;
  logic             qclk_q, eclk_q, cpu_rst_n_q;
  logic             wrap, e_rise, e_fall;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no
    // latch can be inferred.
    wrap     = (pre_q == PW'(DIV - 1));
    pre_d    = wrap ? '0 : pre_q + PW'(1);
    ph_d     = wrap ? ph_q + 2'd1 : ph_q;
    e_rise   = wrap && (ph_q == 2'd0);
    e_fall   = wrap && (ph_q == 2'd2);
    ecount_d = e_fall ? ecount_q + CTR_W'(1) : ecount_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Phase 3 makes the first advance after release land on phase 0.
      pre_q       <= '0;
      ph_q        <= 2'd3;
      qclk_q      <= 1'b0;
      eclk_q      <= 1'b0;
      ecount_q    <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pre_q    <= pre_d;
      ph_q     <= ph_d;
      // Clocks are decoded from the next phase so they toggle with it.
      qclk_q   <= (ph_d == 2'd0) || (ph_d == 2'd1);
      eclk_q   <= (ph_d == 2'd1) || (ph_d == 2'd2);
      ecount_q <= ecount_d;
      if (e_fall && ecount_d == CTR_W'(RST_CYCLES)) cpu_rst_n_q <= 1'b1;
    end
  end

  assign qclk        = qclk_q;
  assign eclk        = eclk_q;
  assign ecount      = ecount_q;
  assign cpu_reset_n = cpu_rst_n_q;

  // Channel numbers at or above NCHAN match no instance and are dropped.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic we_c;
    assign we_c = cfg.cfg_we && (cfg.cfg_chan == CW'(c));

    mmu09_irq_chan #(.CTR_W(CTR_W)) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .eval_i   (e_rise),
      .ecount_i (ecount_q),
      .we_i     (we_c),
      .sel_i    (cfg.cfg_sel),
      .data_i   (cfg.cfg_data),
      .int_n_o  (int_n[c]),
      .busy_o   (chan_busy[c])
    );
  end

endmodule
